// File: rtl/rsp_s2_prep_pack.sv
// rsp_s2_prep_pack: packs LANES narrow samples from a valid/ready stream into
// one wide word and pushes it into the downstream FWFT FIFO.
// Word layout on fifo_din: {last, lane_cnt_m1, data}, lane 0 in the LSBs.
// An accumulator fills the next word while a one-entry output stage waits on
// the FIFO, so one completed word can be absorbed while the FIFO is full.
module rsp_s2_prep_pack #(
   parameter int IN_WIDTH   = 32,
   parameter int LANES      = 4,
   parameter int OUT_WIDTH  = IN_WIDTH * LANES,
   parameter int LANE_BITS  = $clog2(LANES),
   parameter int FIFO_WIDTH = OUT_WIDTH + LANE_BITS + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  fifo_push,
   output logic [FIFO_WIDTH-1:0] fifo_din,
   input  logic                  fifo_full,
   output logic [15:0]           word_count,
   output logic [15:0]           frame_count
);

   logic [OUT_WIDTH-1:0]  acc_data;
   logic [OUT_WIDTH-1:0]  acc_data_nxt;
   logic [LANE_BITS-1:0]  acc_cnt;
   logic [LANE_BITS-1:0]  acc_lcnt;
   logic                  acc_last;
   logic                  acc_done;
   logic                  out_vld;
   logic [FIFO_WIDTH-1:0] out_word;
   logic                  accept;
   logic                  complete;
   logic                  xfer;

   assign fifo_push = out_vld && !fifo_full;
   assign xfer      = acc_done && (!out_vld || fifo_push);
   // Anything accepted while rst is high is discarded by the reset itself.
   assign in_ready  = rst || !acc_done || xfer;
   assign accept    = in_valid && in_ready;
   assign complete  = accept && (in_last || (acc_cnt == LANE_BITS'(LANES - 1)));
   assign fifo_din  = out_word;

   // Next accumulator contents: start from zero on lane 0 so unused lanes of a
   // short word stay zero, then drop the incoming sample into its lane.
   always_comb begin
      acc_data_nxt = (acc_cnt == '0) ? '0 : acc_data;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (acc_cnt == LANE_BITS'(l)) begin
            acc_data_nxt[l*IN_WIDTH +: IN_WIDTH] = in_data;
         end
      end
   end

   // Accumulator: fill lanes, mark the word done on the last lane or in_last,
   // hold it until the output stage takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_data <= '0;
         acc_cnt  <= '0;
         acc_lcnt <= '0;
         acc_last <= 1'b0;
         acc_done <= 1'b0;
      end else begin
         if (accept) begin
            acc_data <= acc_data_nxt;
            acc_cnt  <= complete ? '0 : acc_cnt + LANE_BITS'(1);
         end
         if (complete) begin
            acc_done <= 1'b1;
            acc_last <= in_last;
            acc_lcnt <= acc_cnt;
         end else if (xfer) begin
            acc_done <= 1'b0;
         end
      end
   end

   // Output stage: reload on transfer (same cycle as a push gives no bubble),
   // otherwise empty after the FIFO accepts the word.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_word <= '0;
      end else if (xfer) begin
         out_vld  <= 1'b1;
         out_word <= {acc_last, acc_lcnt, acc_data};
      end else if (fifo_push) begin
         out_vld  <= 1'b0;
      end
   end

   // Statistics: words pushed and frame-ending words pushed, both wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_count  <= '0;
         frame_count <= '0;
      end else if (fifo_push) begin
         word_count <= word_count + 16'd1;
         if (out_word[FIFO_WIDTH-1]) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_rsp_s2_prep_pack.sv
// Testbench for rsp_s2_prep_pack: directed scenarios plus randomized traffic,
// checked against a queue-based model of packed words and push counters.
module tb_rsp_s2_prep_pack;

   localparam int IN_WIDTH   = 32;
   localparam int LANES      = 4;
   localparam int OUT_WIDTH  = IN_WIDTH * LANES;
   localparam int LANE_BITS  = $clog2(LANES);
   localparam int FIFO_WIDTH = OUT_WIDTH + LANE_BITS + 1;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic [IN_WIDTH-1:0]   in_data = '0;
   logic                  in_last = 1'b0;
   logic                  in_ready;
   logic                  fifo_push;
   logic [FIFO_WIDTH-1:0] fifo_din;
   logic                  fifo_full = 1'b0;
   logic [15:0]           word_count;
   logic [15:0]           frame_count;

   rsp_s2_prep_pack #(
      .IN_WIDTH (IN_WIDTH),
      .LANES    (LANES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .fifo_push   (fifo_push),
      .fifo_din    (fifo_din),
      .fifo_full   (fifo_full),
      .word_count  (word_count),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [IN_WIDTH-1:0]   frame_q[$];
   logic [FIFO_WIDTH-1:0] exp_q[$];
   logic [FIFO_WIDTH-1:0] din_q[$];
   logic [FIFO_WIDTH-1:0] exp_word;
   int                    push_cyc_q[$];
   int unsigned           m_words = 0;
   int unsigned           m_frames = 0;
   int unsigned           n_accept = 0;
   int unsigned           n_push = 0;
   int                    cyc = 0;
   int                    last_send_cyc = 0;

   function automatic logic [FIFO_WIDTH-1:0] make_word(input logic [IN_WIDTH-1:0] s[$], input logic last);
      logic [OUT_WIDTH-1:0] d;
      d = '0;
      foreach (s[i]) d = d | (OUT_WIDTH'(s[i]) << (i * IN_WIDTH));
      return {last, LANE_BITS'(s.size() - 1), d};
   endfunction

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: score pushes against the model, then feed accepted beats in
   always @(negedge clk) begin
      if (rst) begin
         frame_q.delete();
         exp_q.delete();
         m_words  = 0;
         m_frames = 0;
      end else begin
         if (fifo_push) begin
            n_push++;
            push_cyc_q.push_back(cyc);
            din_q.push_back(fifo_din);
            check("word_count", word_count, 16'(m_words));
            check("frame_count", frame_count, 16'(m_frames));
            check("push_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_word = exp_q.pop_front();
               check("push_word", fifo_din, exp_word);
               m_words++;
               if (exp_word[FIFO_WIDTH-1]) m_frames++;
            end
         end
         if (in_valid && in_ready) begin
            n_accept++;
            frame_q.push_back(in_data);
            if (in_last || frame_q.size() == LANES) begin
               exp_q.push_back(make_word(frame_q, in_last));
               frame_q.delete();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      fifo_full = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      din_q.delete();
      push_cyc_q.delete();
      n_push = 0;
   endtask

   task automatic send(input logic [IN_WIDTH-1:0] d, input logic l);
      int unsigned k = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      if (k == 200) check("send_ready", in_ready, 1);
      last_send_cyc = cyc;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_push(input int unsigned target);
      int unsigned k = 0;
      while (n_push < target && k < 100) begin
         tick();
         k++;
      end
      if (n_push < target) check("push_timeout", n_push, target);
   endtask

   task automatic check_reset_state();
      check("rst_word_count", word_count, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_fifo_push", fifo_push, 0);
      check("rst_fifo_din", fifo_din, 0);
      check("rst_in_ready", in_ready, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FIFO_WIDTH-1:0] w;
      int unsigned base;
      int release_cyc;

      // Reset state
      do_reset();
      check_reset_state();

      // Full-rate packing
      clear_logs();
      for (int i = 0; i < 8; i++) send(IN_WIDTH'(i), i == 7);
      wait_push(2);
      tick();
      w = {1'b0, 2'd3, 128'h00000003_00000002_00000001_00000000};
      check("full_word0", din_q[0], w);
      w = {1'b1, 2'd3, 128'h00000007_00000006_00000005_00000004};
      check("full_word1", din_q[1], w);
      check("full_gap", push_cyc_q[1] - push_cyc_q[0], 4);
      check("full_latency", push_cyc_q[1] - last_send_cyc, 2);
      check("full_word_count", word_count, 2);
      check("full_frame_count", frame_count, 1);

      // Partial frame
      do_reset();
      clear_logs();
      send(32'hA, 0);
      send(32'hB, 0);
      send(32'hC, 1);
      wait_push(1);
      w = {1'b1, 2'd2, 128'h00000000_0000000C_0000000B_0000000A};
      check("partial_word", din_q[0], w);
      check("partial_latency", push_cyc_q[0] - last_send_cyc, 2);

      // Last on first lane
      clear_logs();
      send(32'h55, 1);
      wait_push(1);
      w = {1'b1, 2'd0, 128'h00000000_00000000_00000000_00000055};
      check("lane0_word", din_q[0], w);

      // Backpressure: one pending word plus one full accumulator, then stall
      do_reset();
      clear_logs();
      base = n_accept;
      fifo_full = 1'b1;
      in_valid  = 1'b1;
      in_last   = 1'b0;
      for (int i = 0; i < 12; i++) begin
         in_data = IN_WIDTH'(n_accept - base);
         tick();
      end
      check("bp_accepted", n_accept - base, 8);
      check("bp_ready_low", in_ready, 0);
      check("bp_no_push", n_push, 0);
      in_valid  = 1'b0;
      fifo_full = 1'b0;
      release_cyc = cyc;
      #1;
      check("bp_release_ready", in_ready, 1);
      wait_push(2);
      check("bp_release_push", push_cyc_q[0], release_cyc);
      check("bp_back_to_back", push_cyc_q[1] - push_cyc_q[0], 1);
      w = {1'b0, 2'd3, 128'h00000003_00000002_00000001_00000000};
      check("bp_word0", din_q[0], w);
      w = {1'b0, 2'd3, 128'h00000007_00000006_00000005_00000004};
      check("bp_word1", din_q[1], w);

      // Reset mid-frame discards the partial word
      do_reset();
      clear_logs();
      send(32'hE0, 0);
      send(32'hE1, 0);
      do_reset();
      tick();
      check("midrst_no_push", n_push, 0);
      for (int i = 0; i < 4; i++) send(IN_WIDTH'(32'h10 + i), i == 3);
      wait_push(1);
      tick();
      w = {1'b1, 2'd3, 128'h00000013_00000012_00000011_00000010};
      check("midrst_word", din_q[0], w);
      check("midrst_word_count", word_count, 1);
      check("midrst_frame_count", frame_count, 1);

      // Randomized traffic with random backpressure
      do_reset();
      clear_logs();
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_last   = ($urandom_range(0, 9) < 2);
         in_data   = $urandom;
         fifo_full = ($urandom_range(0, 9) < 3);
         tick();
      end
      in_valid  = 1'b0;
      fifo_full = 1'b0;
      if (frame_q.size() != 0) send($urandom, 1);
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
      tick();
      check("rand_drained", exp_q.size(), 0);
      check("rand_word_count", word_count, 16'(m_words));
      check("rand_frame_count", frame_count, 16'(m_frames));

      // Reset with a pending word and a full accumulator
      fifo_full = 1'b1;
      in_valid  = 1'b1;
      in_last   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_data = $urandom;
         tick();
      end
      do_reset();
      check_reset_state();

      // Counter wrap: 65537 single-beat frames at full rate
      clear_logs();
      base = n_accept;
      in_valid = 1'b1;
      in_last  = 1'b1;
      for (int i = 0; i < 65537; i++) begin
         in_data = $urandom;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("wrap_accepted", n_accept - base, 65537);
      wait_push(65537);
      tick();
      check("wrap_word_count", word_count, 1);
      check("wrap_frame_count", frame_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
